// File: rtl/bus_arbiter.sv
// Round-robin arbiter that shares one RAM slave between NUM_CLIENTS rq/ack masters.
// One transaction is in flight at a time; a stalled RAM is abandoned after TIMEOUT BUSY cycles.
module bus_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int TIMEOUT     = 31
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLIENTS-1:0]            cl_rq,
  input  logic [NUM_CLIENTS-1:0]            cl_wr_ni,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_address,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_dataW,
  output logic [NUM_CLIENTS-1:0]            cl_ack,
  output logic [DATA_WIDTH-1:0]             cl_dataR,
  output logic                              mem_rq,
  output logic                              mem_wr_ni,
  output logic [ADDR_WIDTH-1:0]             mem_address,
  output logic [DATA_WIDTH-1:0]             mem_dataW,
  input  logic                              mem_ack,
  input  logic [DATA_WIDTH-1:0]             mem_dataR,
  output logic [NUM_CLIENTS-1:0]            grant,
  output logic                              busy,
  output logic                              timeout_err
);

  localparam int            IW        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [7:0]    LAST_WAIT = 8'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(NUM_CLIENTS - 1);
  localparam logic [IW:0]   N_WIDE    = (IW + 1)'(NUM_CLIENTS);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [IW-1:0]          r_rrPtr;
  logic [IW-1:0]          r_grantId;
  logic [NUM_CLIENTS-1:0] r_grant;
  logic [7:0]             r_waitCnt;
  logic                   r_memRq;
  logic [IW-1:0]          w_pickId;
  logic                   w_anyRq;
  logic                   w_timeout;
  logic [IW:0]            w_idx;

  // Scan from the highest offset down so the closest requester to r_rrPtr wins.
  always_comb begin
    w_pickId = '0;
    w_anyRq  = 1'b0;
    w_idx    = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_rrPtr} + (IW + 1)'(i);
      if (w_idx >= N_WIDE) begin
        w_idx = w_idx - N_WIDE;
      end
      if (cl_rq[w_idx[IW-1:0]]) begin
        w_pickId = w_idx[IW-1:0];
        w_anyRq  = 1'b1;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_anyRq) begin
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          w_nextState = RELEASE;
        end else if (r_waitCnt == LAST_WAIT) begin
          w_timeout   = 1'b1;
          w_nextState = RELEASE;
        end
      end
      RELEASE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rrPtr   <= '0;
      r_grantId <= '0;
      r_grant   <= '0;
      r_waitCnt <= '0;
      r_memRq   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (w_anyRq) begin
            r_grantId <= w_pickId;
            r_grant   <= NUM_CLIENTS'(1) << w_pickId;
            r_memRq   <= 1'b1;
            r_waitCnt <= '0;
          end
        end
        BUSY: begin
          r_waitCnt <= r_waitCnt + 8'd1;
          if (w_nextState == RELEASE) begin
            r_memRq <= 1'b0;
          end
        end
        RELEASE: begin
          r_rrPtr <= (r_grantId == LAST_ID) ? '0 : r_grantId + 1'b1;
          r_grant <= '0;
        end
        default: begin
          r_memRq <= 1'b0;
        end
      endcase
    end
  end

  // Grant is one-hot or zero, so OR-ing the selected fields gives zeros when idle.
  always_comb begin
    mem_address = '0;
    mem_wr_ni   = 1'b0;
    mem_dataW   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (r_grant[i]) begin
        mem_address = cl_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wr_ni   = cl_wr_ni[i];
        mem_dataW   = cl_dataW[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign cl_ack      = (r_state == BUSY && mem_ack) ? r_grant : '0;
  assign cl_dataR    = mem_dataR;
  assign mem_rq      = r_memRq;
  assign grant       = r_grant;
  assign busy        = (r_state != IDLE);
  assign timeout_err = w_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: table-driven single transactions through a
// scoreboard, plus contention, pointer wrap, timeout and mid-transaction reset sequences.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 31;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    cl_rq, cl_wr_ni, cl_ack, grant;
  logic [N*AW-1:0] cl_address;
  logic [N*DW-1:0] cl_dataW;
  logic [DW-1:0]   cl_dataR, mem_dataW, mem_dataR;
  logic            mem_rq, mem_wr_ni, mem_ack, busy, timeout_err;
  logic [AW-1:0]   mem_address;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            client;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] expRead;
  } vec_t;

  typedef struct {
    int            client;
    logic          wr;
    logic [DW-1:0] expRead;
  } exp_t;

  vec_t vecs[8];
  exp_t sbQ[$];

  bus_arbiter #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cl_rq(cl_rq), .cl_wr_ni(cl_wr_ni),
    .cl_address(cl_address), .cl_dataW(cl_dataW), .cl_ack(cl_ack), .cl_dataR(cl_dataR),
    .mem_rq(mem_rq), .mem_wr_ni(mem_wr_ni), .mem_address(mem_address),
    .mem_dataW(mem_dataW), .mem_ack(mem_ack), .mem_dataR(mem_dataR),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: acks ackDelay cycles after mem_rq rises, one-cycle pulse.
  logic [DW-1:0] ramMem [2**AW];
  logic          ramAck = 1'b0;
  int            ramCnt = 0;
  bit            ackEnable = 1'b1;
  int            ackDelay = 5;
  logic          forceAck = 1'b0;

  assign mem_ack   = ramAck | forceAck;
  assign mem_dataR = ramMem[mem_address];

  always @(posedge clk) begin
    if (ramAck) begin
      ramAck <= 1'b0;
      ramCnt <= 0;
    end else if (mem_rq && ackEnable) begin
      if (ramCnt == ackDelay - 1) begin
        ramAck <= 1'b1;
        if (mem_wr_ni) ramMem[mem_address] <= mem_dataW;
      end
      ramCnt <= ramCnt + 1;
    end else begin
      ramCnt <= 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic applyStimulus(input int c, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cl_wr_ni[c]           = wr;
    cl_address[c*AW +: AW] = a;
    cl_dataW[c*DW +: DW]   = d;
    cl_rq[c]              = 1'b1;
  endtask

  function automatic int oneHotIndex(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic doReset();
    reset    = 1'b0;
    cl_rq    = '0;
    forceAck = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic waitAck(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (cl_ack != '0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_wait: no cl_ack within 100 cycles, expected one pulse");
    end
  endtask

  task automatic runTransaction(input vec_t v);
    logic [N-1:0] oh;
    bit           seen;
    exp_t         e;
    oh = N'(1) << v.client;
    applyStimulus(v.client, v.wr, v.addr, v.data);
    sbQ.push_back('{v.client, v.wr, v.expRead});
    #1;
    checkOutput("rq_latency", mem_rq, 0);
    @(negedge clk);
    checkOutput("grant", grant, oh);
    checkOutput("mem_rq", mem_rq, 1);
    checkOutput("mem_address", mem_address, v.addr);
    checkOutput("mem_wr_ni", mem_wr_ni, v.wr);
    if (v.wr) checkOutput("mem_dataW", mem_dataW, v.data);
    waitAck(seen);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      if (seen) begin
        checkOutput("ack_align", mem_ack, 1);
        checkOutput("cl_ack", cl_ack, N'(1) << e.client);
        if (!e.wr) checkOutput("cl_dataR", cl_dataR, e.expRead);
      end
    end
    cl_rq[v.client] = 1'b0;
    @(negedge clk);
    checkOutput("release_busy", busy, 1);
    checkOutput("release_mem_rq", mem_rq, 0);
    checkOutput("release_grant", grant, oh);
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_grant", grant, 0);
  endtask

  initial begin
    int  order[$];
    int  gap;
    int  busyCnt;
    int  idx;
    bit  seen;
    bit  ackSeen;
    logic prevRq;

    for (int i = 0; i < 2**AW; i++) ramMem[i] = '0;
    cl_rq      = '0;
    cl_wr_ni   = '1;
    cl_address = '1;
    cl_dataW   = '1;
    reset      = 1'b0;
    #1;
    checkOutput("reset_grant", grant, 0);
    checkOutput("reset_mem_rq", mem_rq, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_cl_ack", cl_ack, 0);
    checkOutput("reset_timeout", timeout_err, 0);
    checkOutput("reset_mem_address", mem_address, 0);
    checkOutput("reset_mem_wr_ni", mem_wr_ni, 0);
    checkOutput("reset_mem_dataW", mem_dataW, 0);
    doReset();

    // Stray ack while idle must not reach any client.
    forceAck = 1'b1;
    #1;
    checkOutput("stray_ack", cl_ack, 0);
    @(negedge clk);
    checkOutput("stray_busy", busy, 0);
    forceAck = 1'b0;

    vecs[0] = '{2, 1'b1, 4'h3, 8'hA5, 8'h00};
    vecs[1] = '{0, 1'b0, 4'h3, 8'h00, 8'hA5};
    vecs[2] = '{1, 1'b1, 4'h7, 8'h3C, 8'h00};
    vecs[3] = '{3, 1'b1, 4'hF, 8'h5A, 8'h00};
    vecs[4] = '{1, 1'b0, 4'h7, 8'h00, 8'h3C};
    vecs[5] = '{3, 1'b0, 4'hF, 8'h00, 8'h5A};
    vecs[6] = '{2, 1'b1, 4'h3, 8'h11, 8'h00};
    vecs[7] = '{0, 1'b0, 4'h3, 8'h00, 8'h11};
    for (int i = 0; i < 8; i++) runTransaction(vecs[i]);

    // Contention: all four request continuously from reset release.
    doReset();
    for (int c = 0; c < N; c++) applyStimulus(c, 1'b1, AW'(c), DW'(c));
    gap    = 0;
    prevRq = 1'b0;
    for (int cyc = 0; cyc < 400 && order.size() < 6; cyc++) begin
      @(negedge clk);
      if (mem_rq && !prevRq) begin
        order.push_back(oneHotIndex(grant));
        if (order.size() > 1) checkOutput("contention_gap", gap, 2);
        gap = 0;
      end else if (!mem_rq) begin
        gap++;
      end
      prevRq = mem_rq;
    end
    if (order.size() < 6) begin
      checks++;
      errors++;
      $display("[TB] FAIL contention_count: got %0d grants, expected 6", order.size());
    end
    for (int i = 0; i < order.size(); i++) checkOutput("contention_order", order[i], i % N);

    // Pointer wrap: serve client 3, then clients 3 and 1 compete.
    doReset();
    runTransaction('{3, 1'b1, 4'h2, 8'h77, 8'h00});
    applyStimulus(1, 1'b0, 4'h2, 8'h00);
    applyStimulus(3, 1'b0, 4'h2, 8'h00);
    for (int t = 0; t < 2; t++) begin
      waitAck(seen);
      idx = oneHotIndex(cl_ack);
      checkOutput("wrap_order", idx, (t == 0) ? 1 : 3);
      if (seen) checkOutput("wrap_dataR", cl_dataR, 8'h77);
      if (idx >= 0) cl_rq[idx] = 1'b0;
      @(negedge clk);
    end
    cl_rq = '0;

    // Timeout: RAM never acks while client 1 is granted; client 2 waits.
    doReset();
    ackEnable = 1'b0;
    applyStimulus(1, 1'b0, 4'h5, 8'h00);
    applyStimulus(2, 1'b0, 4'h6, 8'h00);
    busyCnt = 0;
    ackSeen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_rq) busyCnt++;
      if (cl_ack != '0) ackSeen = 1'b1;
      if (timeout_err) break;
    end
    checkOutput("timeout_seen", timeout_err, 1);
    checkOutput("timeout_cycles", busyCnt, TO);
    checkOutput("timeout_grant", grant, 4'b0010);
    checkOutput("timeout_no_ack", ackSeen, 0);
    cl_rq[1] = 1'b0;
    @(negedge clk);
    checkOutput("timeout_pulse", timeout_err, 0);
    checkOutput("timeout_release", mem_rq, 0);
    ackEnable = 1'b1;
    waitAck(seen);
    checkOutput("timeout_next", cl_ack, 4'b0100);
    cl_rq = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset mid-BUSY: move pointer to 2, start client 2, reset between edges.
    doReset();
    runTransaction('{1, 1'b0, 4'h7, 8'h00, 8'h3C});
    ackEnable = 1'b0;
    applyStimulus(2, 1'b0, 4'h1, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_mem_rq", mem_rq, 0);
    checkOutput("async_grant", grant, 0);
    checkOutput("async_busy", busy, 0);
    @(negedge clk);
    reset     = 1'b1;
    ackEnable = 1'b1;
    cl_rq     = '1;
    waitAck(seen);
    checkOutput("restart_client0", cl_ack, 4'b0001);
    cl_rq = '0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one ram slave between NUM_CLIENTS client masters over the rq/ack/wr_ni bus.
- Round-robin arbitration; one transaction in flight at a time.
- Muxes the granted client's address, wr_ni and dataW onto the RAM side, and routes the RAM ack back to the granted client only.
- Sits between the client instances and the ram instance in the system-level top.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..8).
- DATA_WIDTH, 8, data bus width.
- ADDR_WIDTH, 4, address bus width.
- TIMEOUT, 31, max cycles in BUSY waiting for mem_ack before abort (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cl_rq  input  NUM_CLIENTS  per-client request; bit i = client i.
- cl_wr_ni  input  NUM_CLIENTS  per-client 1=write, 0=read.
- cl_address  input  NUM_CLIENTS*ADDR_WIDTH  packed; client i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- cl_dataW  input  NUM_CLIENTS*DATA_WIDTH  packed write data, same packing.
- cl_ack  output  NUM_CLIENTS  per-client ack; only the granted bit can be 1.
- cl_dataR  output  DATA_WIDTH  read data, broadcast to all clients; valid with cl_ack.
- mem_rq  output  1  request to ram.
- mem_wr_ni  output  1  write/read to ram.
- mem_address  output  ADDR_WIDTH  address to ram.
- mem_dataW  output  DATA_WIDTH  write data to ram.
- mem_ack  input  1  ram acknowledge (one-cycle pulse).
- mem_dataR  input  DATA_WIDTH  ram read data.
- grant  output  NUM_CLIENTS  one-hot current owner; 0 when idle.
- busy  output  1  1 in BUSY or RELEASE.
- timeout_err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (reset=0, async, takes effect immediately, including mid-transaction):
  - state=IDLE, rr_ptr=0, grant_id=0, wait counter=0.
  - mem_rq=0, grant=0, cl_ack=0, busy=0, timeout_err=0.
  - mem_address, mem_wr_ni and mem_dataW drive 0 while grant=0.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - If any cl_rq bit is 1, pick the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_CLIENTS.
  - Register grant_id and the one-hot grant; next state BUSY. Counter cleared.
  - No request: stay IDLE.
- BUSY:
  - mem_rq=1 (registered; first asserted the cycle after the IDLE decision, so arbitration latency is 1 cycle).
  - mem_address, mem_wr_ni and mem_dataW mux combinationally from client grant_id. Clients hold their fields stable until ack.
  - Counter increments every cycle.
  - On mem_ack=1: cl_ack[grant_id]=mem_ack in the same cycle (combinational, no added latency) and cl_dataR=mem_dataR. Next state RELEASE.
  - If the counter reaches TIMEOUT with no ack: timeout_err=1 for one cycle, no cl_ack, next state RELEASE.
  - mem_ack while not in BUSY is ignored; cl_ack stays 0.
- RELEASE:
  - Exactly one cycle. mem_rq=0, grant still held.
  - rr_ptr <= (grant_id+1) mod NUM_CLIENTS (wrap from NUM_CLIENTS-1 to 0).
  - Next state IDLE.
  - The granted client drops rq the cycle after ack. Its rq is not sampled in RELEASE.
- Fairness: with continuous requests from all clients, the grant order is strictly cyclic. No client waits more than NUM_CLIENTS-1 transactions.
- Request withdrawal: a drop of cl_rq[grant_id] during BUSY does not abort. The transaction completes and ack is still pulsed.
- New requests arriving during BUSY/RELEASE are queued implicitly, since rq is level-held. They are evaluated in the next IDLE.
- cl_dataR = mem_dataR at all times. Clients qualify it with their ack.
- Minimum transaction length: IDLE + BUSY(1 + RAM ack delay) + RELEASE.

Test Plan:
- Single write: client 2 writes addr 4'h3, data 8'hA5 with RAM DELAY_ACK=5 -> mem_rq rises 1 cycle after cl_rq[2]; grant=4'b0100; mem_address=3; cl_ack[2] pulses 1 cycle aligned with mem_ack; other ack bits stay 0.
- Read-back: client 0 reads addr 3 after the write above -> cl_dataR=8'hA5 in the cycle cl_ack[0]=1.
- Contention: cl_rq=4'b1111 held continuously from reset release -> grants in order 0,1,2,3,0,1. Each grant separated by exactly one RELEASE and one IDLE cycle.
- Wrap/pointer: after client 3 is served, clients 3 and 1 request -> client 1 granted first (rr_ptr=0 skips idle 0), then 3.
- Timeout: RAM ack tied 0, TIMEOUT=31, client 1 requests -> timeout_err pulses after 31 BUSY cycles; cl_ack stays 0; next grant goes to client 2 if it is requesting.
- Reset mid-operation: reset=0 asserted in BUSY between clock edges -> mem_rq, grant and busy go 0 immediately. After release, arbitration restarts from client 0.
